// File: rtl/im_loader.sv
// im_loader: loads a byte stream into the instruction memory as big-endian
// 32-bit words, then checks a trailing checksum byte. busy holds the CPU in
// stall while the image is being loaded.
//
// Handshake: a byte moves on a rising edge where in_valid=1 and in_ready=1.
// The source holds in_data stable while in_valid=1 and in_ready=0. in_ready
// depends only on the registered state, never on in_valid, so there is no
// combinational path from the byte source back to itself.
module im_loader #(
    parameter int NMEM = 128,
    parameter int AW   = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   nwords,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          im_we,
    output logic [AW-1:0] im_waddr,
    output logic [31:0]   im_wdata,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CSUM = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [AW:0] NMEM_W = (AW+1)'(NMEM);

    state_t        state;
    logic [AW:0]   count;     // words to load, already clamped to NMEM
    logic [AW-1:0] widx;      // address of the word being assembled
    logic [1:0]    bidx;      // byte position inside the current word
    logic [7:0]    sum;       // running mod-256 sum of data bytes
    logic [23:0]   wbuf;      // first three bytes of the current word

    logic          beat;
    logic          last_word;
    logic [AW:0]   count_clamped;
    logic [7:0]    sum_plus_in;

    // Status outputs are decoded straight from the state register.
    assign in_ready = (state == LOAD) || (state == CSUM);
    assign busy     = (state == LOAD) || (state == CSUM);
    assign done     = (state == DONE);

    // Helper terms for the sequencer.
    assign beat          = in_valid && in_ready;
    assign last_word     = ({1'b0, widx} == (count - 1'b1));
    assign count_clamped = (nwords > NMEM_W) ? NMEM_W : nwords;
    assign sum_plus_in   = sum + in_data;

    // Load sequencer: packs bytes, issues one write per word, checks the sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            widx     <= '0;
            bidx     <= '0;
            sum      <= '0;
            wbuf     <= '0;
            err      <= 1'b0;
            im_we    <= 1'b0;
            im_waddr <= '0;
            im_wdata <= '0;
        end else begin
            // im_we is a single-cycle pulse unless re-armed below
            im_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        count <= count_clamped;
                        widx  <= '0;
                        bidx  <= '0;
                        sum   <= '0;
                        err   <= 1'b0;
                        state <= (count_clamped != '0) ? LOAD : CSUM;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        wbuf <= {wbuf[15:0], in_data};
                        sum  <= sum_plus_in;
                        bidx <= bidx + 2'd1;
                        if (bidx == 2'd3) begin
                            // word complete: write it next cycle
                            im_we    <= 1'b1;
                            im_waddr <= widx;
                            im_wdata <= {wbuf, in_data};
                            if (last_word) begin
                                state <= CSUM;
                            end else begin
                                widx <= widx + 1'b1;
                            end
                        end
                    end
                end
                CSUM: begin
                    if (beat) begin
                        // a correct checksum byte brings the total to zero
                        err   <= (sum_plus_in != 8'd0);
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: directed scenarios for im_loader. Expected memory writes are
// queued as each scenario is issued; a monitor pops them as im_we fires.
module tb_im_loader;

    localparam int NMEM = 128;
    localparam int AW   = 7;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW:0]   nwords;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          im_we;
    logic [AW-1:0] im_waddr;
    logic [31:0]   im_wdata;
    logic          busy;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;

    logic [AW+31:0] exp_q[$];
    logic [7:0]     stim_q[$];

    im_loader #(.NMEM(NMEM), .AW(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .nwords   (nwords),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .im_we    (im_we),
        .im_waddr (im_waddr),
        .im_wdata (im_wdata),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: every write must match the head of exp_q
    always @(negedge clk) begin
        if (!reset && im_we) begin
            we_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h, none expected", im_waddr, im_wdata);
            end else begin
                logic [AW+31:0] e;
                e = exp_q.pop_front();
                if ({im_waddr, im_wdata} !== e) begin
                    errors++;
                    $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                             im_waddr, im_wdata, e[AW+31:32], e[31:0]);
                end
            end
        end
    end

    // tasks start and end 1 time unit after a rising edge
    task automatic do_start(input int n);
        start  = 1'b1;
        nwords = (AW+1)'(n);
        @(posedge clk); #1;
        start  = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_in_ready", 64'(in_ready), 64'd1);
        chk("start_done_low", 64'(done), 64'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit poke_start);
        bit rdy;
        int n;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            if (poke_start && g == 0) begin
                start  = 1'b1;
                nwords = 8'd5;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        in_valid = 1'b1;
        in_data  = b;
        rdy = 1'b0;
        n   = 0;
        while (!rdy && n < 200) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: in_ready 0 expected 1 within 200 cycles");
        end
    endtask

    task automatic send_stream(input int gap, input int poke_at);
        for (int i = 0; i < stim_q.size(); i++) begin
            send_byte(stim_q[i], gap, (i == poke_at));
        end
    endtask

    task automatic check_end(input string name, input logic exp_err, input int exp_we);
        chk({name, "_done"}, 64'(done), 64'd1);
        chk({name, "_busy"}, 64'(busy), 64'd0);
        chk({name, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({name, "_err"}, 64'(err), 64'(exp_err));
        chk({name, "_writes"}, 64'(we_cnt), 64'(exp_we));
        chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic base_stream(input logic [7:0] csum);
        stim_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        stim_q.push_back(csum);
        exp_q.push_back({7'd0, 32'h12345678});
        exp_q.push_back({7'd1, 32'h9ABCDEF0});
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({name, "_im_we"}, 64'(im_we), 64'd0);
        chk({name, "_im_waddr"}, 64'(im_waddr), 64'd0);
        chk({name, "_im_wdata"}, 64'(im_wdata), 64'd0);
        chk({name, "_busy"}, 64'(busy), 64'd0);
        chk({name, "_done"}, 64'(done), 64'd0);
        chk({name, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        nwords   = '0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // good checksum
        base_stream(8'hC8);
        we_cnt = 0;
        do_start(2);
        send_stream(0, -1);
        check_end("good", 1'b0, 2);

        // bad checksum, restarted from DONE
        base_stream(8'hC9);
        we_cnt = 0;
        do_start(2);
        send_stream(0, -1);
        check_end("bad", 1'b1, 2);

        // valid every third cycle, start pulsed mid-load
        base_stream(8'hC8);
        we_cnt = 0;
        do_start(2);
        send_stream(2, 5);
        check_end("gaps", 1'b0, 2);

        // nwords beyond NMEM is clamped to 128 words
        stim_q.delete();
        for (int i = 0; i < 512; i++) stim_q.push_back(8'h01);
        stim_q.push_back(8'h00);
        for (int a = 0; a < 128; a++) exp_q.push_back({7'(a), 32'h01010101});
        we_cnt = 0;
        do_start(200);
        send_stream(0, -1);
        check_end("clamp", 1'b0, 128);

        // reset one cycle after the 6th byte
        exp_q.push_back({7'd0, 32'h12345678});
        we_cnt = 0;
        do_start(2);
        stim_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        send_stream(0, -1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_outputs("midreset");
        repeat (3) @(posedge clk);
        #1;
        chk("midreset_writes", 64'(we_cnt), 64'd1);
        chk("midreset_queue_empty", 64'(exp_q.size()), 64'd0);

        // full load after the reset
        base_stream(8'hC8);
        we_cnt = 0;
        do_start(2);
        send_stream(0, -1);
        check_end("after_reset", 1'b0, 2);

        // zero words: checksum beat only
        stim_q = '{8'h00};
        we_cnt = 0;
        do_start(0);
        send_stream(0, -1);
        check_end("zero", 1'b0, 0);

        // restart from DONE with one word: 01 02 03 04, checksum F6
        stim_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hF6};
        exp_q.push_back({7'd0, 32'h01020304});
        we_cnt = 0;
        do_start(1);
        send_stream(0, -1);
        check_end("one", 1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/im_loader.md
# im_loader

Instruction-memory loader for the five-stage MIPS CPU. It accepts a byte stream over a valid/ready handshake and packs each four bytes into a big-endian 32-bit word. Each word is written through the instruction memory's write port, at the same word addresses the fetch stage reads via pc[8:2]. A trailing checksum byte validates the image, and `busy` holds the CPU in stall until loading finishes.

## Interface

Parameters:
- NMEM, 128, instruction memory depth in words
- AW, 7, word address width; NMEM <= 2**AW

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a load; honoured only in IDLE or DONE
- nwords  input  AW+1  number of words to load, sampled on accepted start
- in_valid  input  1  byte source has data
- in_data  input  8  byte from source
- in_ready  output  1  loader accepts a byte this cycle
- im_we  output  1  instruction memory write enable, one-cycle pulse per word
- im_waddr  output  AW  word address of the write
- im_wdata  output  32  word to write
- busy  output  1  load in progress; CPU stall/hold
- done  output  1  load complete, held until next accepted start or reset
- err  output  1  checksum mismatch, valid while done=1

## Operation

- States: IDLE, LOAD, CSUM, DONE.
- Beat: a cycle with in_valid=1 and in_ready=1. in_ready=1 only in LOAD and CSUM, and is decoded from the registered state only.
- IDLE/DONE + start=1:
  - Latch count = min(nwords, NMEM); nwords > NMEM is clamped.
  - Clear word index, byte index (2 bits), checksum accumulator (8 bits), done and err.
  - Next state is LOAD if count > 0, otherwise CSUM.
- start in LOAD or CSUM is ignored.
- LOAD, per beat:
  - wbuf <= {wbuf[23:0], in_data}, so the first byte lands in bits 31:24.
  - sum <= sum + in_data, mod 256.
  - Byte index increments.
- LOAD, on the beat with byte index 3:
  - Next cycle: im_we=1, im_wdata = completed word, im_waddr = word index.
  - The word index then increments.
  - If this was word count-1, the next state is CSUM.
- CSUM, on beat: err <= ((sum + in_data) mod 256 != 0). The checksum byte is the two's-complement negation of the sum of all data bytes. Next state is DONE.
- DONE: done=1, busy=0, in_ready=0. Memory is not rewritten on error; err only flags the mismatch.
- busy=1 in LOAD and CSUM.
- Word index never exceeds NMEM-1, because count is clamped; no address wrap occurs.
- Reset values: state IDLE, in_ready=0, im_we=0, im_waddr=0, im_wdata=0, busy=0, done=0, err=0, all counters and sum 0.

## Timing

- start accepted at edge k: busy=1 and in_ready=1 from cycle k+1.
- 4th byte of a word accepted at edge j: im_we=1 during cycle j+1 only, with address and data stable in that cycle.
- Writes are always one cycle apart at minimum; maximum throughput is one byte per cycle.
- A full load takes 4·count + 1 beats.
- Checksum beat at edge c: done=1, busy=0 and err valid from cycle c+1.
- in_valid gaps: no state change, no write, no duplicate write. Partial-word bytes are held indefinitely.
- Reset mid-load: at the reset edge everything returns to reset values. A pending im_we that would have fired the next cycle is suppressed, and no further writes occur.
- Reset has priority over start in the same cycle.
- Load starts on start=1 in DONE exactly as from IDLE; done drops the cycle after start is accepted.

## Test plan

- nwords=2, bytes 12 34 56 78 9A BC DE F0, checksum C8 -> writes addr0=0x12345678 and addr1=0x9ABCDEF0, one im_we pulse each; done=1, err=0.
- Same stream with checksum C9 -> same two writes; done=1, err=1.
- Same stream with in_valid asserted only every third cycle, plus start pulsed mid-load -> identical writes, exactly two im_we pulses, start ignored.
- nwords=200, NMEM=128, 512 bytes of value 01 followed by checksum 00 (512·1 mod 256 = 0) -> exactly 128 writes of 0x01010101 to addr 0..127; done=1, err=0.
- Reset asserted one cycle after the 6th byte of the first scenario -> only addr0 written, all outputs 0; a subsequent full load succeeds.
- nwords=0, checksum byte 00 -> no im_we, done=1, err=0 after one beat. Then start again from DONE -> done drops and busy rises the next cycle.
